// File: rtl/spio_spinnaker_link_async_to_sync_rx_pkg.sv
// Shared definitions for the SpiNNaker 2-of-7 link (tx and rx sides).
// Symbol constants, wire count and the popcount/classify helpers.
package spio_spinnaker_link_async_to_sync_rx_pkg;

  localparam int         SYM_W    = 7;
  localparam logic [6:0] EOP_2OF7 = 7'b1100000;
  localparam logic [6:0] NO_WIRES = 7'b0000000;

  typedef enum logic [1:0] {
    SYM_NONE,
    SYM_GOOD,
    SYM_BAD
  } sym_kind_t;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < SYM_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic sym_kind_t classify(input logic [2:0] n);
    sym_kind_t k;
    k = SYM_NONE;
    if (n == 3'd2) begin
      k = SYM_GOOD;
    end else if (n >= 3'd3) begin
      k = SYM_BAD;
    end
    return k;
  endfunction

endpackage

// File: rtl/spio_spinnaker_link_rx_fifo.sv
// Show-ahead flit buffer for the 2-of-7 link receiver.
// Binary pointers wrap mod BUFF_DEPTH; a separate count gives full/valid.
module spio_spinnaker_link_rx_fifo
  import spio_spinnaker_link_async_to_sync_rx_pkg::*;
#(
  parameter int BUFF_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic             push,
  input  logic [SYM_W-1:0] push_data,
  output logic             full,
  output logic [SYM_W-1:0] flt_data_2of7,
  output logic             flt_vld,
  input  logic             flt_rdy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH + 1)'(BUFF_DEPTH);

  logic [SYM_W-1:0]      mem [BUFF_DEPTH];
  logic [ADDR_WIDTH-1:0] wrp;
  logic [ADDR_WIDTH-1:0] rdp;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full          = (count == DEPTH_C);
  assign flt_vld       = (count != '0);
  assign flt_data_2of7 = mem[rdp];

  // full is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = flt_vld && flt_rdy;

  // storage: written only on an accepted push
  always_ff @(posedge CLK_IN) begin
    if (do_push) begin
      mem[wrp] <= push_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      wrp   <= '0;
      rdp   <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wrp <= wrp + 1'b1;
      end
      if (do_pop) begin
        rdp <= rdp + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spio_spinnaker_link_async_to_sync_rx.sv
// SpiNNaker 2-of-7 NRZ link receiver: sync, symbol detect, ack, buffer.
// Optional error counter port/logic enabled by SPIO_SL_RX_ERR_CNT_EN.
module spio_spinnaker_link_async_to_sync_rx
  import spio_spinnaker_link_async_to_sync_rx_pkg::*;
#(
  parameter int BUFF_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic [SYM_W-1:0] SL_DATA_2OF7_IN,
  output logic             SL_ACK_OUT,
  output logic [SYM_W-1:0] flt_data_2of7,
  output logic             flt_vld,
  input  logic             flt_rdy
`ifdef SPIO_SL_RX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  logic [SYM_W-1:0] sync1;
  logic [SYM_W-1:0] s_data;
  logic [SYM_W-1:0] baseline;
  logic [SYM_W-1:0] chg;
  logic [2:0]       n;
  sym_kind_t        kind;
  logic             full;
  logic             push;
  logic             bad;
  logic             resync;

  // two-flop synchronizer; nothing else looks at the raw wires
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      sync1  <= NO_WIRES;
      s_data <= NO_WIRES;
    end else begin
      sync1  <= SL_DATA_2OF7_IN;
      s_data <= sync1;
    end
  end

  // classify the wires changed since the last accepted symbol
  always_comb begin
    chg    = s_data ^ baseline;
    n      = popcount7(chg);
    kind   = classify(n);
    push   = 1'b0;
    bad    = 1'b0;
    unique case (1'b1)
      (kind == SYM_GOOD): push = !full;
      (kind == SYM_BAD):  bad  = 1'b1;
      default: ;
    endcase
    resync = push || bad;
  end

  // accept or drop a symbol: move baseline and return an ack edge
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      baseline   <= NO_WIRES;
      SL_ACK_OUT <= 1'b0;
    end else if (resync) begin
      baseline   <= s_data;
      SL_ACK_OUT <= ~SL_ACK_OUT;
    end
  end

`ifdef SPIO_SL_RX_ERR_CNT_EN
  // saturating count of symbols with three or more changed wires
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      err_cnt <= 8'h00;
    end else if (bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

  spio_spinnaker_link_rx_fifo #(
    .BUFF_DEPTH (BUFF_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .CLK_IN        (CLK_IN),
    .RESET_IN      (RESET_IN),
    .push          (push),
    .push_data     (chg),
    .full          (full),
    .flt_data_2of7 (flt_data_2of7),
    .flt_vld       (flt_vld),
    .flt_rdy       (flt_rdy)
  );

endmodule
